// File: rtl/la_pkg.sv
// Logic analyser shared definitions: acquisition state encoding and the
// default widths shared by the dispatcher, acquisition and transmit stages.
package la_pkg;

    localparam int CH_W       = 8;
    localparam int DEPTH_LOG2 = 9;
    localparam int PRESCALE_W = 16;

    typedef enum logic [1:0] {
        ACQ_IDLE    = 2'd0,
        ACQ_ARM     = 2'd1,
        ACQ_CAPTURE = 2'd2,
        ACQ_DONE    = 2'd3
    } acq_state_t;

endpackage

// File: rtl/acq_prescaler.sv
// Sample-rate divider: down-counter that ticks when it reaches zero and
// reloads, giving one tick every reload+1 enabled cycles.
module acq_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] reload,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = enable && (cnt == '0);

    // Reload on arm or after each tick, otherwise count down while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load || tick) begin
            cnt <= reload;
        end else if (enable) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/acq_sampler.sv
// Acquisition stage: arms a pattern trigger, then captures a fixed burst of
// probe samples into sample RAM. Define ACQ_SYNC_EN for 2 extra input syncs.
module acq_sampler #(
    parameter int CH_W       = 8,
    parameter int DEPTH_LOG2 = 9,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  grant,
    output logic                  done,
    input  logic [CH_W-1:0]       probe_in,
    input  logic [CH_W-1:0]       trig_mask,
    input  logic [CH_W-1:0]       trig_value,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [CH_W-1:0]       mem_wdata,
    output logic [DEPTH_LOG2:0]   sample_count,
    output logic                  busy
);

    import la_pkg::*;

    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0] CNT_LAST = {1'b0, {DEPTH_LOG2{1'b1}}};

    acq_state_t            state;
    logic [CH_W-1:0]       probe_q;
    logic [CH_W-1:0]       mask_l;
    logic [CH_W-1:0]       value_l;
    logic [PRESCALE_W-1:0] prescale_l;
    logic                  arm_start;
    logic                  pre_en;
    logic                  tick;
    logic                  hit;
    logic [PRESCALE_W-1:0] pre_reload;

`ifdef ACQ_SYNC_EN
    logic [CH_W-1:0] sync_a;
    logic [CH_W-1:0] sync_b;

    // Two-flop synchroniser ahead of the sampling register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= '0;
            sync_b  <= '0;
            probe_q <= '0;
        end else begin
            sync_a  <= probe_in;
            sync_b  <= sync_a;
            probe_q <= sync_b;
        end
    end
`else
    // Single sampling register; all compares and data use probe_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            probe_q <= '0;
        end else begin
            probe_q <= probe_in;
        end
    end
`endif

    assign arm_start  = (state == ACQ_IDLE) && grant;
    assign pre_en     = (state == ACQ_ARM) || (state == ACQ_CAPTURE);
    assign pre_reload = arm_start ? prescale : prescale_l;
    assign hit        = ((probe_q ^ value_l) & mask_l) == '0;

    acq_prescaler #(
        .W(PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .load   (arm_start),
        .enable (pre_en),
        .reload (pre_reload),
        .tick   (tick)
    );

    // Acquisition FSM with registered RAM write port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACQ_IDLE;
            done         <= 1'b0;
            busy         <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            sample_count <= '0;
            mask_l       <= '0;
            value_l      <= '0;
            prescale_l   <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                ACQ_IDLE: begin
                    if (grant) begin
                        state        <= ACQ_ARM;
                        busy         <= 1'b1;
                        sample_count <= '0;
                        mask_l       <= trig_mask;
                        value_l      <= trig_value;
                        prescale_l   <= prescale;
                    end
                end
                ACQ_ARM: begin
                    if (!grant) begin
                        state <= ACQ_IDLE;
                        busy  <= 1'b0;
                    end else if (tick && hit) begin
                        state        <= ACQ_CAPTURE;
                        mem_we       <= 1'b1;
                        mem_addr     <= '0;
                        mem_wdata    <= probe_q;
                        sample_count <= CNT_ONE;
                    end
                end
                ACQ_CAPTURE: begin
                    if (!grant) begin
                        state <= ACQ_IDLE;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        mem_we       <= 1'b1;
                        mem_addr     <= sample_count[DEPTH_LOG2-1:0];
                        mem_wdata    <= probe_q;
                        sample_count <= sample_count + CNT_ONE;
                        if (sample_count == CNT_LAST) begin
                            state <= ACQ_DONE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ACQ_DONE: begin
                    if (!grant) begin
                        state <= ACQ_IDLE;
                        done  <= 1'b0;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= ACQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acq_sampler.sv
// Directed bench for acq_sampler (DEPTH_LOG2=4) with a cycle-level
// reference model and hand-computed scenario expectations.
module tb_acq_sampler;

    localparam int DEPTH = 16;
`ifdef ACQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        grant = 1'b0;
    logic [7:0]  probe_in = '0;
    logic [7:0]  trig_mask = '0;
    logic [7:0]  trig_value = '0;
    logic [15:0] prescale = '0;
    logic        done;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [4:0]  sample_count;
    logic        busy;

    acq_sampler #(
        .CH_W(8),
        .DEPTH_LOG2(4),
        .PRESCALE_W(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .grant        (grant),
        .done         (done),
        .probe_in     (probe_in),
        .trig_mask    (trig_mask),
        .trig_value   (trig_value),
        .prescale     (prescale),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .sample_count (sample_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model state: bursts described by arm edge, period and count.
    logic [7:0] pipe [LAT];
    bit         m_act, m_trig, m_fin;
    int         m_e0, m_p;
    logic [7:0] m_mask, m_val;
    bit         e_we, e_busy, e_done;
    int         e_addr, e_cnt;
    logic [7:0] e_wdata;

    always @(posedge clk) begin
        logic [7:0] s;
        cyc = cyc + 1;
        s = pipe[LAT-1];
        e_we = 1'b0;
        if (rst) begin
            m_act = 0; m_trig = 0; m_fin = 0;
            m_e0 = 0; m_p = 0; m_mask = '0; m_val = '0;
            e_busy = 0; e_done = 0; e_addr = 0; e_cnt = 0; e_wdata = '0;
            for (int k = 0; k < LAT; k++) pipe[k] = '0;
        end else begin
            if (m_act) begin
                if (!grant) begin
                    m_act = 0;
                    e_busy = 0;
                end else if (cyc > m_e0 && (cyc - m_e0) % (m_p + 1) == 0 &&
                             (m_trig || ((s ^ m_val) & m_mask) == 8'h00)) begin
                    e_we = 1'b1;
                    e_addr = e_cnt;
                    e_wdata = s;
                    e_cnt = e_cnt + 1;
                    m_trig = 1;
                    if (e_cnt == DEPTH) begin
                        m_act = 0;
                        m_fin = 1;
                        e_busy = 0;
                    end
                end
            end else if (m_fin) begin
                if (!grant) begin
                    m_fin = 0;
                    e_done = 0;
                end else begin
                    e_done = 1;
                end
            end else if (grant) begin
                m_act = 1;
                m_e0 = cyc;
                m_p = int'(prescale);
                m_mask = trig_mask;
                m_val = trig_value;
                m_trig = 0;
                e_cnt = 0;
                e_busy = 1;
            end
            for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = probe_in;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            vectors++;
            if (mem_we !== e_we || mem_addr !== 4'(e_addr) ||
                mem_wdata !== e_wdata || sample_count !== 5'(e_cnt) ||
                busy !== e_busy || done !== e_done) begin
                errors++;
                $display("FAIL cycle %0d: we=%b addr=%0d data=%h cnt=%0d busy=%b done=%b need we=%b addr=%0d data=%h cnt=%0d busy=%b done=%b",
                         cyc, mem_we, mem_addr, mem_wdata, sample_count, busy, done,
                         e_we, e_addr, e_wdata, e_cnt, e_busy, e_done);
            end
        end
    end

    // Write log for the scenario-level literal checks.
    int wc[$];
    int wa[$];
    int wd[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wc.push_back(cyc);
            wa.push_back(int'(mem_addr));
            wd.push_back(int'(mem_wdata));
        end
    end

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wc.delete();
        wa.delete();
        wd.delete();
    endtask

    task automatic wait_done(string name, int lim);
        for (int i = 0; i < lim && done !== 1'b1; i++) @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s: done=%b after %0d cycles, need 1", name, done, lim);
        end
    endtask

    task automatic wait_writes(string name, int n, int lim);
        for (int i = 0; i < lim && wc.size() < n; i++) @(negedge clk);
        check(name, wc.size() >= n ? 1 : 0, 1);
    endtask

    initial begin
        int chg, g, dcyc;

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cnt", int'(sample_count), 0);
        check("rst_addr", int'(mem_addr), 0);
        rst = 1'b0;

        // Trigger match on channel 0, no divider.
        trig_mask = 8'h01; trig_value = 8'h01; prescale = 16'd0;
        probe_in = 8'h00; grant = 1'b1;
        repeat (20) @(negedge clk);
        check("s1_no_early_trig", int'(sample_count), 0);
        clear_log();
        probe_in = 8'h01;
        chg = cyc;
        wait_done("s1_done", 100);
        dcyc = cyc;
        check("s1_nwrites", wc.size(), 16);
        check("s1_first_addr", wa[0], 0);
        check("s1_first_data", wd[0], 1);
        check("s1_latency", wc[0] - chg, 1 + LAT);
        check("s1_contig", wc[15] - wc[0], 15);
        check("s1_last_addr", wa[15], 15);
        check("s1_done_lag", dcyc - wc[15], 1);
        check("s1_count", int'(sample_count), 16);
        repeat (5) @(negedge clk);
        check("s1_done_held", int'(done), 1);
        check("s1_no_rearm", int'(busy), 0);
        grant = 1'b0;
        repeat (2) @(negedge clk);
        check("s1_done_clear", int'(done), 0);

        // Divider of 4, trigger on the first tick.
        trig_mask = 8'h00; prescale = 16'd3; probe_in = 8'h3c;
        clear_log();
        grant = 1'b1;
        g = cyc;
        wait_done("s2_done", 200);
        check("s2_nwrites", wc.size(), 16);
        check("s2_first", wc[0] - g, 5);
        check("s2_gap_a", wc[1] - wc[0], 4);
        check("s2_gap_b", wc[15] - wc[14], 4);
        for (int i = 0; i < 16; i++) check("s2_addr", wa[i], i);
        grant = 1'b0;
        repeat (2) @(negedge clk);

        // Abort after five writes, then re-arm.
        prescale = 16'd1;
        clear_log();
        grant = 1'b1;
        wait_writes("s3_five_writes", 5, 100);
        grant = 1'b0;
        repeat (2) @(negedge clk);
        check("s3_nwrites", wc.size(), 5);
        check("s3_count", int'(sample_count), 5);
        check("s3_busy", int'(busy), 0);
        repeat (6) @(negedge clk);
        check("s3_no_done", int'(done), 0);
        check("s3_count_held", int'(sample_count), 5);
        clear_log();
        grant = 1'b1;
        @(negedge clk);
        check("s3_rearm_cnt", int'(sample_count), 0);
        wait_done("s3_done", 200);
        check("s3_rearm_addr", wa[0], 0);
        check("s3_rearm_n", wc.size(), 16);
        grant = 1'b0;
        repeat (2) @(negedge clk);

        // Trigger config latched at arm.
        prescale = 16'd0; trig_mask = 8'hff; trig_value = 8'h5a;
        probe_in = 8'h00;
        grant = 1'b1;
        @(negedge clk);
        trig_value = 8'h00;
        repeat (5) @(negedge clk);
        check("s4_no_trig", int'(sample_count), 0);
        check("s4_armed", int'(busy), 1);
        clear_log();
        probe_in = 8'h5a;
        wait_done("s4_done", 100);
        check("s4_data", wd[0], 8'h5a);
        grant = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-capture.
        trig_mask = 8'h00;
        clear_log();
        grant = 1'b1;
        wait_writes("s5_three_writes", 3, 100);
        rst = 1'b1;
        @(negedge clk);
        check("s5_we", int'(mem_we), 0);
        check("s5_addr", int'(mem_addr), 0);
        check("s5_done", int'(done), 0);
        check("s5_busy", int'(busy), 0);
        check("s5_cnt", int'(sample_count), 0);
        rst = 1'b0;
        grant = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/acq_sampler.md
Name: acq_sampler

Overview:
- Acquisition stage of the logic analyser; sits directly downstream of the task dispatcher's acquisition grant.
- While granted, it arms a pattern trigger on the probe inputs, then captures a fixed-depth burst of samples at a programmable rate into the sample RAM write port.
- When the burst completes it raises done, which the dispatcher uses to hand the RAM to the transmit stage.

Parameters:
- CH_W, 8, number of probe channels (sample width).
- DEPTH_LOG2, 9, log2 of capture depth; burst length = 2**DEPTH_LOG2 samples.
- PRESCALE_W, 16, width of the sample-rate divider value.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high. The block is clocked by clk.
- grant  in  1  level; acquisition permitted while high.
- done  out  1  level; burst complete, held until grant falls.
- probe_in  in  CH_W  raw probe channels.
- trig_mask  in  CH_W  1 = channel participates in trigger.
- trig_value  in  CH_W  required level per masked channel.
- prescale  in  PRESCALE_W  sample every prescale+1 clocks.
- mem_we  out  1  RAM write strobe, one cycle per sample.
- mem_addr  out  DEPTH_LOG2  RAM write address.
- mem_wdata  out  CH_W  RAM write data.
- sample_count  out  DEPTH_LOG2+1  samples written in current/last burst.
- busy  out  1  high in ARM or CAPTURE.

Behaviour:
- Reset values: state IDLE; done, mem_we, busy = 0; mem_addr, mem_wdata, sample_count = 0; prescale counter = 0.
- probe_in is registered once (probe_q) every cycle. All trigger compares and captured data use probe_q.
- Prescaler:
  - Down-counter reloaded with the latched prescale value; tick when it reaches 0.
  - prescale=0 gives a tick every cycle.
  - Counter is reloaded on ARM entry, so the first tick occurs prescale+1 cycles after entry.
- States: IDLE, ARM, CAPTURE, DONE.
- IDLE:
  - grant=1 → ARM next cycle.
  - trig_mask, trig_value and prescale are latched on this transition; later changes are ignored until the next arm.
- ARM:
  - On each tick, if ((probe_q ^ value_l) & mask_l) == 0 → CAPTURE. That tick's sample is written at address 0.
  - mask_l=0 triggers on the first tick.
- CAPTURE:
  - Each tick writes one sample; mem_addr increments by 1 and sample_count by 1.
  - After write number 2**DEPTH_LOG2 (address 2**DEPTH_LOG2-1) → DONE.
  - mem_addr never wraps within a burst.
- Write timing:
  - mem_we, mem_addr and mem_wdata are registered.
  - mem_we is high exactly one cycle, the cycle after the tick; mem_wdata equals probe_q at the tick.
- DONE:
  - done=1 and busy=0; sample_count holds 2**DEPTH_LOG2.
  - grant=0 → IDLE and done=0 next cycle.
- grant falls in ARM or CAPTURE (abort):
  - → IDLE next cycle; done stays 0.
  - An in-flight mem_we still completes.
  - sample_count holds the partial count until the next arm clears it to 0.
- rst mid-operation: immediate return to reset values on the next edge, regardless of state or pending write.
- grant held high after done: remain in DONE; no re-arm until grant drops and rises again.

Optional Feature:
- ACQ_SYNC_EN defined: two extra flop stages on probe_in before probe_q, for asynchronous probes. Trigger-to-write latency increases by 2 cycles; captured data is otherwise identical.
- ACQ_SYNC_EN undefined: single register stage only.

Decomposition:
- Shared package la_pkg holds:
  - state encoding constants (ACQ_IDLE, ACQ_ARM, ACQ_CAPTURE, ACQ_DONE);
  - default widths CH_W / DEPTH_LOG2 / PRESCALE_W, shared with the dispatcher and transmit stage.
- Sub-module acq_prescaler: load, enable, reload value in; tick out.

Test Plan:
- Trigger match, no divider: DEPTH_LOG2=4, prescale=0, mask=0x01, value=0x01; probe goes 0x00→0x01 at cycle 20 → first mem_we writes addr 0 data 0x01; 16 consecutive writes; done=1 one cycle after the last write; sample_count=16.
- Divider: prescale=3, mask=0 → writes exactly every 4 cycles, first write 5 cycles after ARM entry; addresses 0..15 in order.
- Abort: drop grant after 5 writes → IDLE next cycle, done never asserts, sample_count=5. Re-grant → sample_count=0, next burst starts at addr 0.
- Config latching: change trig_value during ARM → trigger still uses the value latched at arm.
- Reset: assert rst mid-CAPTURE → next cycle state IDLE, mem_we=0, mem_addr=0, done=0.
- ACQ_SYNC_EN: repeat the first scenario → same data; each write occurs 2 cycles later.
